fifo_bridge_ctl_module: RTL

FIFO_BRIDGE_CTL_MODULE -- requirements
Module: fifo_bridge_ctl_module

---
 rtl/fifo_bridge_ctl_module.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_bridge_ctl_module.sv
// fifo_bridge_ctl_module
// Moves one word at a time from a read FIFO (loopback) or from an internal
// incrementing pattern generator into a write FIFO. Each word walks the
// FSM once: S_IDLE -> [S_RD -> S_CAP ->] S_WAITF -> S_WR -> S_IDLE.
//
// Handshake: Read_Req_Sig and Write_Req_Sig are single-cycle request
// pulses. A read request in cycle t means FIFO_Read_Data is valid in
// cycle t+1. A write request is issued only when Full_Sig was low in
// S_WAITF, and FIFO_Write_Data is valid and stable for the whole cycle in
// which Write_Req_Sig is high. The two requests are never high together.
module fifo_bridge_ctl_module #(
  parameter int                DATA_W   = 8,
  parameter int                CNT_W    = 16,
  parameter logic [DATA_W-1:0] PAT_INIT = '0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Enable,
  input  logic              Mode_Sel,
  input  logic              Empty_Sig,
  input  logic [DATA_W-1:0] FIFO_Read_Data,
  output logic              Read_Req_Sig,
  input  logic              Full_Sig,
  output logic              Write_Req_Sig,
  output logic [DATA_W-1:0] FIFO_Write_Data,
  output logic [CNT_W-1:0]  Xfer_Count,
  output logic              Busy,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_CAP   = 3'd2,
    S_WAITF = 3'd3,
    S_WR    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;      // source of the word in flight
  logic [DATA_W-1:0] data_q, data_d;      // drives FIFO_Write_Data
  logic [DATA_W-1:0] pat_q, pat_d;        // next test-pattern value
  logic [CNT_W-1:0]  cnt_q, cnt_d;        // completed writes, wraps silently
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic              busy_q, busy_d;

  // Next-state and datapath logic; request and busy outputs are decoded
  // from the next state so they come straight out of flops.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // Mode_Sel is only looked at here, so a change mid-word applies
        // to the next word.
        if (Enable) begin
          if (Mode_Sel) begin
            mode_d  = 1'b1;
            data_d  = pat_q;
            state_d = S_WAITF;
          end else if (!Empty_Sig) begin
            mode_d  = 1'b0;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        data_d  = FIFO_Read_Data;
        state_d = S_WAITF;
      end
      S_WAITF: begin
        if (!Full_Sig) begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mode_q) begin
          pat_d = pat_q + DATA_W'(1);
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rd_req_d = (state_d == S_RD);
    wr_req_d = (state_d == S_WR);
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any word in flight.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      data_q   <= '0;
      pat_q    <= PAT_INIT;
      cnt_q    <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      pat_q    <= pat_d;
      cnt_q    <= cnt_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      busy_q   <= busy_d;
    end
  end

  assign Read_Req_Sig    = rd_req_q;
  assign Write_Req_Sig   = wr_req_q;
  assign FIFO_Write_Data = data_q;
  assign Xfer_Count      = cnt_q;
  assign Busy            = busy_q;
  assign dbg_state       = state_q;

endmodule
